// File: rtl/level_state_if.sv
// Signal bundle between the hazard/door logic and the level sequencer.
// master drives the game inputs; slave is the sequencer that owns the status outputs.
interface level_state_if;
    logic       frame_tick;
    logic       start_key;
    logic       player1_dead;
    logic       player2_dead;
    logic       player1_at_door;
    logic       player2_at_door;
    logic       hazard_reset;
    logic       players_frozen;
    logic [1:0] game_state;
    logic [1:0] who_died;
    logic [7:0] death_count;
    logic [9:0] level_time;

    modport master (
        output frame_tick, start_key, player1_dead, player2_dead,
               player1_at_door, player2_at_door,
        input  hazard_reset, players_frozen, game_state, who_died,
               death_count, level_time
    );

    modport slave (
        input  frame_tick, start_key, player1_dead, player2_dead,
               player1_at_door, player2_at_door,
        output hazard_reset, players_frozen, game_state, who_died,
               death_count, level_time
    );
endinterface

// File: rtl/level_state_controller.sv
// Level sequencer: starts levels, detects death and win, issues the hazard_reset
// respawn pulse and keeps per-level death count and elapsed seconds.
module level_state_controller #(
    parameter int DEATH_HOLD_FRAMES = 120,
    parameter int WIN_HOLD_FRAMES   = 180,
    parameter int FRAMES_PER_SEC    = 60
) (
    input logic          Clk,
    input logic          Reset,
    level_state_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;
    localparam logic [1:0] ST_WIN  = 2'd3;

    localparam int HOLD_MAX = (DEATH_HOLD_FRAMES > WIN_HOLD_FRAMES) ?
                              DEATH_HOLD_FRAMES : WIN_HOLD_FRAMES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int SUB_W    = $clog2(FRAMES_PER_SEC + 1);

    logic [1:0]        state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n, hold_inc;
    logic [SUB_W-1:0]  sub_cnt, sub_n;
    logic [9:0]        time_cnt, time_n;
    logic [7:0]        death_cnt, death_n;
    logic [1:0]        who, who_n;
    logic              hr, hr_n, hr_d;
    logic              frozen;
    logic              start_prev;
    logic              start_edge;
    logic              blank;
    logic              new_level;

    assign start_edge = bus.start_key & ~start_prev;
    // Hazard latches clear one cycle after the pulse, so stale dead flags are ignored for two cycles.
    assign blank      = hr | hr_d;
    assign hold_inc   = hold_cnt + HOLD_W'(bus.frame_tick);

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        sub_n     = sub_cnt;
        time_n    = time_cnt;
        death_n   = death_cnt;
        who_n     = who;
        hr_n      = 1'b0;
        new_level = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge) new_level = 1'b1;
            end
            ST_PLAY: begin
                if (bus.frame_tick) begin
                    if (sub_cnt == SUB_W'(FRAMES_PER_SEC - 1)) begin
                        sub_n = '0;
                        if (time_cnt != 10'd999) time_n = time_cnt + 10'd1;
                    end else begin
                        sub_n = sub_cnt + SUB_W'(1);
                    end
                end
                if ((bus.player1_dead | bus.player2_dead) & ~blank) begin
                    state_n = ST_DEAD;
                    hold_n  = '0;
                    who_n   = {bus.player2_dead, bus.player1_dead};
                    if (death_cnt != 8'hFF) death_n = death_cnt + 8'd1;
                end else if (bus.player1_at_door & bus.player2_at_door) begin
                    state_n = ST_WIN;
                    hold_n  = '0;
                end
            end
            ST_DEAD: begin
                hold_n = hold_inc;
                if (start_edge || (hold_inc >= HOLD_W'(DEATH_HOLD_FRAMES))) begin
                    state_n = ST_PLAY;
                    hold_n  = '0;
                    hr_n    = 1'b1;
                end
            end
            default: begin
                if (start_edge && (hold_cnt == HOLD_W'(WIN_HOLD_FRAMES))) begin
                    new_level = 1'b1;
                end else if (bus.frame_tick && (hold_cnt != HOLD_W'(WIN_HOLD_FRAMES))) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
        endcase
        if (new_level) begin
            state_n = ST_PLAY;
            hold_n  = '0;
            sub_n   = '0;
            time_n  = '0;
            death_n = '0;
            who_n   = '0;
            hr_n    = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            sub_cnt    <= '0;
            time_cnt   <= '0;
            death_cnt  <= '0;
            who        <= '0;
            hr         <= 1'b0;
            hr_d       <= 1'b0;
            frozen     <= 1'b1;
            start_prev <= 1'b1;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            sub_cnt    <= sub_n;
            time_cnt   <= time_n;
            death_cnt  <= death_n;
            who        <= who_n;
            hr         <= hr_n;
            hr_d       <= hr;
            frozen     <= (state_n != ST_PLAY);
            start_prev <= bus.start_key;
        end
    end

    assign bus.game_state     = state;
    assign bus.hazard_reset   = hr;
    assign bus.players_frozen = frozen;
    assign bus.who_died       = who;
    assign bus.death_count    = death_cnt;
    assign bus.level_time     = time_cnt;

endmodule

// File: tb/tb_level_state_controller.sv
// Bench for level_state_controller: directed scenarios plus random traffic,
// every cycle compared against a rule-level reference model.
module tb_level_state_controller;

    localparam int DHF = 120;
    localparam int WHF = 180;
    localparam int FPS = 60;

    logic Clk;
    logic Reset;
    level_state_if bus();

    level_state_controller #(
        .DEATH_HOLD_FRAMES(DHF),
        .WIN_HOLD_FRAMES(WHF),
        .FRAMES_PER_SEC(FPS)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int hr_cnt   = 0;

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: game rules evaluated once per clock on the sampled inputs
    int m_st, m_hr, m_hr_prev, m_frz, m_who, m_dc, m_lt, m_sub, m_hold, m_sprev;
    int m_edge, m_blank, m_pulse, m_new;
    logic [23:0] exp_q[$];
    logic [23:0] exp_e;

    always @(posedge Clk) begin
        if (Reset) begin
            m_st = 0; m_hr = 0; m_hr_prev = 0; m_frz = 1; m_who = 0;
            m_dc = 0; m_lt = 0; m_sub = 0; m_hold = 0; m_sprev = 1;
        end else begin
            m_edge  = (bus.start_key && !m_sprev) ? 1 : 0;
            m_blank = (m_hr != 0 || m_hr_prev != 0) ? 1 : 0;
            m_pulse = 0;
            m_new   = 0;
            case (m_st)
                0: if (m_edge != 0) m_new = 1;
                1: begin
                    if (bus.frame_tick) begin
                        m_sub++;
                        if (m_sub == FPS) begin
                            m_sub = 0;
                            if (m_lt < 999) m_lt++;
                        end
                    end
                    if ((bus.player1_dead || bus.player2_dead) && m_blank == 0) begin
                        m_st   = 2;
                        m_hold = 0;
                        m_who  = 2 * int'(bus.player2_dead) + int'(bus.player1_dead);
                        if (m_dc < 255) m_dc++;
                    end else if (bus.player1_at_door && bus.player2_at_door) begin
                        m_st   = 3;
                        m_hold = 0;
                    end
                end
                2: begin
                    if (bus.frame_tick) m_hold++;
                    if (m_hold >= DHF || m_edge != 0) begin
                        m_st = 1; m_pulse = 1; m_hold = 0;
                    end
                end
                default: begin
                    if (m_edge != 0 && m_hold == WHF) m_new = 1;
                    else if (bus.frame_tick && m_hold < WHF) m_hold++;
                end
            endcase
            if (m_new != 0) begin
                m_st = 1; m_pulse = 1; m_hold = 0; m_sub = 0;
                m_lt = 0; m_dc = 0; m_who = 0;
            end
            m_hr_prev = m_hr;
            m_hr      = m_pulse;
            m_frz     = (m_st != 1) ? 1 : 0;
            m_sprev   = int'(bus.start_key);
        end
        exp_q.push_back({1'(m_hr), 1'(m_frz), 2'(m_st), 2'(m_who), 8'(m_dc), 10'(m_lt)});
    end

    // scoreboard: one expected snapshot per clock, compared half a cycle later
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("hazard_reset",   bus.hazard_reset,   exp_e[23]);
            check("players_frozen", bus.players_frozen, exp_e[22]);
            check("game_state",     bus.game_state,     exp_e[21:20]);
            check("who_died",       bus.who_died,       exp_e[19:18]);
            check("death_count",    bus.death_count,    exp_e[17:10]);
            check("level_time",     bus.level_time,     exp_e[9:0]);
        end
    end

    // driver tasks
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (bus.hazard_reset) hr_cnt++;
        end
    endtask

    task automatic pulse_start();
        bus.start_key = 1'b1;
        step(1);
        bus.start_key = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        bus.frame_tick = 0; bus.start_key = 0;
        bus.player1_dead = 0; bus.player2_dead = 0;
        bus.player1_at_door = 0; bus.player2_at_door = 0;
        step(3);
        check("reset_state", bus.game_state, 0);
        check("reset_frozen", bus.players_frozen, 1);
        Reset = 1'b0;
        step(1);

        // start: key held 3 cycles gives one pulse
        hr_cnt = 0;
        bus.start_key = 1'b1;
        step(1);
        check("start_state", bus.game_state, 1);
        check("start_pulse", bus.hazard_reset, 1);
        step(2);
        bus.start_key = 1'b0;
        step(1);
        check("start_pulse_count", hr_cnt, 1);
        check("start_dc", bus.death_count, 0);
        check("start_lt", bus.level_time, 0);

        // 130 frames of play, then player2 dies
        bus.frame_tick = 1'b1;
        step(130);
        bus.frame_tick = 1'b0;
        check("play_lt", bus.level_time, 2);
        bus.player2_dead = 1'b1;
        step(1);
        check("dead_state", bus.game_state, 2);
        check("dead_who", bus.who_died, 2);
        check("dead_dc", bus.death_count, 1);
        bus.frame_tick = 1'b1;
        hr_cnt = 0;
        step(DHF - 1);
        check("hold_not_done", bus.game_state, 2);
        step(1);
        bus.frame_tick = 1'b0;
        check("hold_restart_state", bus.game_state, 1);
        check("hold_restart_pulse", bus.hazard_reset, 1);
        check("hold_pulse_count", hr_cnt, 1);
        check("hold_keeps_lt", bus.level_time, 2);

        // stale dead flag through blanking window
        step(1);
        check("blank_cycle0", bus.game_state, 1);
        step(1);
        check("blank_cycle1", bus.game_state, 1);
        step(1);
        check("post_blank_dead", bus.game_state, 2);
        check("post_blank_dc", bus.death_count, 2);

        // death beats win in the same cycle
        pulse_start();
        check("edge_restart", bus.game_state, 1);
        bus.player2_dead = 1'b0;
        step(2);
        bus.player1_dead = 1; bus.player2_dead = 1;
        bus.player1_at_door = 1; bus.player2_at_door = 1;
        step(1);
        check("prio_state", bus.game_state, 2);
        check("prio_who", bus.who_died, 3);
        step(1);
        check("prio_no_win", bus.game_state, 2);

        // win, early edge ignored, late edge starts new level
        pulse_start();
        bus.player1_dead = 0; bus.player2_dead = 0;
        step(1);
        check("win_state", bus.game_state, 3);
        check("win_frozen", bus.players_frozen, 1);
        bus.player1_at_door = 0; bus.player2_at_door = 0;
        bus.frame_tick = 1'b1;
        step(100);
        bus.frame_tick = 1'b0;
        pulse_start();
        check("win_early_edge", bus.game_state, 3);
        bus.frame_tick = 1'b1;
        step(WHF - 100);
        bus.frame_tick = 1'b0;
        step(1);
        pulse_start();
        check("win_exit_state", bus.game_state, 1);
        check("win_exit_pulse", bus.hazard_reset, 1);
        check("win_exit_dc", bus.death_count, 0);
        check("win_exit_lt", bus.level_time, 0);

        // saturating death count
        for (int i = 0; i < 260; i++) begin
            step(2);
            bus.player1_dead = 1'b1;
            step(1);
            bus.player1_dead = 1'b0;
            pulse_start();
        end
        check("dc_saturate", bus.death_count, 255);
        step(2);
        bus.player1_dead = 1'b1;
        step(1);
        check("sat_dead_state", bus.game_state, 2);
        check("sat_dc", bus.death_count, 255);

        // reset in DEAD
        Reset = 1'b1;
        step(1);
        check("rst_state", bus.game_state, 0);
        check("rst_pulse", bus.hazard_reset, 0);
        check("rst_frozen", bus.players_frozen, 1);
        check("rst_who", bus.who_died, 0);
        check("rst_dc", bus.death_count, 0);
        check("rst_lt", bus.level_time, 0);
        Reset = 1'b0;
        bus.player1_dead = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 6000; i++) begin
            bus.frame_tick      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) bus.start_key = ~bus.start_key;
            bus.player1_dead    = ($urandom_range(0, 40) == 0);
            bus.player2_dead    = ($urandom_range(0, 40) == 0);
            bus.player1_at_door = ($urandom_range(0, 9) == 0);
            bus.player2_at_door = ($urandom_range(0, 2) == 0);
            Reset               = ($urandom_range(0, 999) == 0);
            step(1);
        end
        Reset = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/level_state_controller.md
# level_state_controller

Game-level sequencer that consumes the sticky `player1_dead` / `player2_dead` flags raised by the hazard controllers (water, fire, goo) and the exit-door flags. It decides when a level starts, ends in death, restarts or is won. It issues the one-cycle `hazard_reset` pulse that clears every hazard's latched death flag and respawns both players. It sits between the hazard/door logic and the player movement and overlay-rendering blocks, and keeps per-level statistics (death count, elapsed seconds).

## Interface
Parameters:
- DEATH_HOLD_FRAMES, 120: frames the death overlay is held before automatic restart.
- WIN_HOLD_FRAMES, 180: minimum frames in WIN before `start_key` is accepted.
- FRAMES_PER_SEC, 60: frame ticks per `level_time` increment.

Ports:
- Clk  in  1  system clock; one clock for the whole block.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start_key  in  1  level-sensitive key; the block detects its rising edge internally.
- player1_dead, player2_dead  in  1 each  sticky death flags from the hazard controllers.
- player1_at_door, player2_at_door  in  1 each  player is inside its exit door.
- hazard_reset  out  1  one-cycle pulse that clears hazard latches and respawns players.
- players_frozen  out  1  high when not in PLAY.
- game_state  out  2  0=IDLE, 1=PLAY, 2=DEAD, 3=WIN.
- who_died  out  2  bit0 = player1, bit1 = player2; captured on entry to DEAD.
- death_count  out  8  deaths this level; saturates at 255.
- level_time  out  10  seconds elapsed in PLAY; saturates at 999.

## Operation
- Start edge:
  - `start_edge = start_key & ~start_prev`.
  - `start_prev` resets to 1, so a key held through reset is not an edge.
- IDLE:
  - On `start_edge`, go to PLAY.
  - Pulse `hazard_reset`; clear `death_count`, `level_time`, the frame counters and `who_died`.
- PLAY:
  - Death is checked first. If `(player1_dead | player2_dead)` and not blanked:
    - go to DEAD;
    - capture `who_died = {player2_dead, player1_dead}`;
    - increment `death_count` (saturating).
  - Otherwise, if both `at_door` flags are high, go to WIN.
  - Death has priority over win in the same cycle.
- Blanking: dead inputs are ignored in PLAY on the cycle `hazard_reset` is high and on the following cycle, because the hazard latches clear one cycle late.
- DEAD:
  - The hold counter increments on each `frame_tick`.
  - When it reaches DEATH_HOLD_FRAMES, or on `start_edge`, go to PLAY and pulse `hazard_reset`.
  - `death_count` and `level_time` are kept across the restart; `who_died` keeps its value.
- WIN:
  - The hold counter increments on `frame_tick` and saturates at WIN_HOLD_FRAMES.
  - `start_edge` is accepted only once the counter equals WIN_HOLD_FRAMES. It then starts a new level exactly as from IDLE.
  - Earlier edges are ignored.
- level_time:
  - In PLAY only, the sub-second counter increments on `frame_tick`.
  - When it reaches FRAMES_PER_SEC it wraps to 0 and `level_time` increments, saturating at 999.
  - Both counters are held in DEAD and WIN.
- The hold counter clears on every state entry.
- `players_frozen = (game_state != PLAY)`, registered together with the state.

## Timing
- All outputs are registered.
- Reset values:
  - `game_state` = IDLE;
  - `hazard_reset` = 0, `players_frozen` = 1;
  - `who_died`, `death_count`, `level_time` = 0.
- Decision at edge N:
  - The state change and `hazard_reset` are visible at edge N+1.
  - `hazard_reset` is high for exactly one cycle, coincident with the first PLAY cycle.
- Death detection latency is 1 cycle from the dead input to `game_state` = DEAD.
- DEATH_HOLD restart happens on the cycle after the DEATH_HOLD_FRAMES-th `frame_tick` counted in DEAD.
- `frame_tick` coincident with a state change:
  - It counts for the old state's counters.
  - The new state's hold counter starts at 0.
- Reset asserted mid-operation:
  - Next cycle, all registers are at their reset values.
  - No `hazard_reset` pulse is generated by Reset.

## Test plan
- Reset then `start_key` high for 3 cycles -> exactly one `hazard_reset` pulse; `game_state` 0→1; `death_count` = 0, `level_time` = 0.
- PLAY with 130 `frame_tick`s -> `level_time` = 2; then `player2_dead` = 1:
  - next cycle `game_state` = 2, `who_died` = 2'b10, `death_count` = 1;
  - after 120 ticks, `hazard_reset` pulse and `game_state` = 1 with `level_time` still 2.
- Dead flag still high during the `hazard_reset` cycle and one cycle after -> no DEAD entry; dead high on the third cycle -> DEAD.
- Both dead and both `at_door` in the same cycle -> DEAD with `who_died` = 2'b11; never WIN.
- Both `at_door` -> WIN:
  - `start_edge` after 100 ticks is ignored;
  - after 180 ticks, `start_edge` gives a `hazard_reset` pulse, PLAY, and `death_count`/`level_time` cleared.
- 256 death/restart cycles -> `death_count` stays 255; Reset asserted in DEAD -> IDLE, all outputs at reset values, `players_frozen` = 1.
